regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port (AD3/WE3/WD3) between two writeback requesters: the ALU writeback path and the multi-cycle memory/load unit. It also serialises the trigger-flag write that sets register TRIGGER_REG to 1. Each requester gets a one-entry holding buffer with a valid/ready handshake. The block exports a read-after-write hazard flag so the issue stage can stall on operands that are still waiting to be written.

## Interface
Parameters:
- ADDRESS_WIDTH, 5: register index width
- DATA_WIDTH, 32: register data width
- TRIGGER_REG, 5: register written with value 1 on a trigger event

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- alu_valid_i  in  1  ALU write request
- alu_ready_o  out  1  ALU request accepted when valid&ready at the edge
- alu_addr_i  in  ADDRESS_WIDTH  ALU destination register
- alu_data_i  in  DATA_WIDTH  ALU write data
- mem_valid_i, mem_ready_o, mem_addr_i, mem_data_i: same as the ALU group, for the memory unit
- trigger_i  in  1  level request to write 1 to TRIGGER_REG
- rs1_i, rs2_i  in  ADDRESS_WIDTH  source registers checked for hazards
- hazard_o  out  1  a pending write targets rs1_i or rs2_i
- AD3_o  out  ADDRESS_WIDTH  register file write address
- WE3_o  out  1  register file write enable
- WD3_o  out  DATA_WIDTH  register file write data
- busy_o  out  1  any buffer full or trigger pending

## Operation
- State:
  - ALU buffer: full flag, addr, data
  - MEM buffer: full flag, addr, data
  - trig_pend flag
  - rr_ptr: 0 means ALU is preferred, 1 means MEM is preferred
- Acceptance:
  - A handshake on either port with addr ≠ 0 loads that port's buffer.
  - A handshake with addr = 0 is accepted and discarded. The buffer stays empty and no write is ever issued.
- trig_pend:
  - Set at any edge where trigger_i = 1.
  - Cleared at the edge where the trigger is granted.
  - trigger_i seen while already pending coalesces into the single pending trigger.
  - If trigger_i = 1 at the granting edge, trig_pend stays set.
- Grant selection uses registered state only, one grant per cycle, in this priority:
  1. trig_pend
  2. If only one buffer is full, that buffer.
  3. If both buffers are full, the buffer selected by rr_ptr.
- After any buffer grant, rr_ptr points to the other requester.
- Write port, driven combinationally from the grant:
  - Granted: WE3_o = 1, with AD3_o/WD3_o taken from the granted entry (TRIGGER_REG/1 for a trigger).
  - No grant: WE3_o = 0, AD3_o = 0, WD3_o = 0.
- Ready:
  - x_ready_o = ~x_full | x_granted_this_cycle, which allows a drain and refill on the same edge.
  - There is no combinational path from valid to ready.
- hazard_o:
  - Asserted when any full buffer's addr equals a non-zero rs1_i or rs2_i.
  - Also asserted when trig_pend = 1 and rs1_i or rs2_i = TRIGGER_REG.
  - Combinational.
- Two buffers holding the same address are written in grant order, so the second grant's value persists. Upstream uses hazard_o to avoid relying on this ordering.

## Timing
- Reset (asynchronous assert):
  - Both buffers empty, trig_pend = 0, rr_ptr = 0.
  - Outputs: WE3_o = 0, AD3_o = 0, WD3_o = 0, both ready = 1, busy_o = 0, hazard_o = 0.
- Reset mid-operation drops all buffered writes immediately. No partial write is issued.
- Latency: a request accepted at edge N drives WE3_o in cycle N+1 when uncontested. The register file commits it at the end of cycle N+1.
- Sustained throughput: one write per cycle in total. With both requesters streaming, each gets every second slot.
- A pending trigger stalls both buffers for exactly one cycle.
- busy_o is registered-state derived and falls in the cycle after the last grant.

## Configuration
- REGFILE_ARB_ROUND_ROBIN_EN
  - Defined: round-robin between the buffers as described above.
  - Undefined: fixed priority, MEM over ALU. rr_ptr is not implemented. The trigger stays highest priority either way.

## Test plan
- Reset: assert rst_n_i with both buffers full -> the same cycle shows WE3_o = 0 and busy_o = 0. After release, alu_ready_o = mem_ready_o = 1.
- Single write: ALU addr 3, data 0xDEADBEEF accepted at edge N -> cycle N+1 shows WE3_o = 1, AD3_o = 3, WD3_o = 0xDEADBEEF. Cycle N+2 shows busy_o = 0.
- Contention: both ports stream continuously, ALU to addr 1 and MEM to addr 2 -> with the macro defined, grants alternate ALU, MEM, ALU… at one write per cycle. With it undefined, MEM wins every contested cycle and the ALU stalls.
- Trigger: pulse trigger_i for one cycle while both buffers are full -> the next cycle writes AD3_o = TRIGGER_REG with WD3_o = 1. The buffers then drain in round-robin order. A 3-cycle trigger_i level results in exactly one trigger write per granted cycle while it is held.
- x0: MEM write to addr 0 with data 0x1234 -> accepted with mem_ready_o = 1, WE3_o stays 0, busy_o stays 0.
- Hazard: ALU buffer holds addr 7 with rs1_i = 7 -> hazard_o = 1. Change rs1_i to 0 and rs2_i to 8 -> hazard_o = 0. After the grant, rs1_i = 7 -> hazard_o = 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port (AD3/WE3/WD3) between
// the ALU writeback path, the memory/load unit and a trigger-flag write.
// Each requester has a one-entry holding buffer with a valid/ready handshake.
// Optional feature macro: REGFILE_ARB_ROUND_ROBIN_EN. When it is defined, the two
// buffers are served round-robin. When it is undefined, MEM has fixed priority over ALU.
module regfile_write_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned TRIGGER_REG   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0]    alu_data_i,
  input  logic                     mem_valid_i,
  output logic                     mem_ready_o,
  input  logic [ADDRESS_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0]    mem_data_i,
  input  logic                     trigger_i,
  input  logic [ADDRESS_WIDTH-1:0] rs1_i,
  input  logic [ADDRESS_WIDTH-1:0] rs2_i,
  output logic                     hazard_o,
  output logic [ADDRESS_WIDTH-1:0] AD3_o,
  output logic                     WE3_o,
  output logic [DATA_WIDTH-1:0]    WD3_o,
  output logic                     busy_o
);

  localparam logic [ADDRESS_WIDTH-1:0] TrigAddr = ADDRESS_WIDTH'(TRIGGER_REG);

  logic                     alu_full_q, alu_full_d;
  logic [ADDRESS_WIDTH-1:0] alu_addr_q, alu_addr_d;
  logic [DATA_WIDTH-1:0]    alu_data_q, alu_data_d;
  logic                     mem_full_q, mem_full_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                     trig_pend_q, trig_pend_d;
  logic                     gnt_trig, gnt_alu, gnt_mem;
  logic                     alu_hs, mem_hs;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic rr_ptr_q, rr_ptr_d;
`endif

  // Grant selection from registered state only: trigger first, then the buffers.
  always_comb begin
    gnt_trig = trig_pend_q;
    gnt_alu  = 1'b0;
    gnt_mem  = 1'b0;
    if (!trig_pend_q) begin
      if (alu_full_q && mem_full_q) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
        gnt_alu = ~rr_ptr_q;
        gnt_mem = rr_ptr_q;
`else
        gnt_mem = 1'b1;
`endif
      end else begin
        gnt_alu = alu_full_q;
        gnt_mem = mem_full_q;
      end
    end
  end

  // Write port, ready, hazard and busy outputs.
  always_comb begin
    WE3_o = 1'b0;
    AD3_o = '0;
    WD3_o = '0;
    if (gnt_trig) begin
      WE3_o = 1'b1;
      AD3_o = TrigAddr;
      WD3_o = DATA_WIDTH'(1);
    end else if (gnt_alu) begin
      WE3_o = 1'b1;
      AD3_o = alu_addr_q;
      WD3_o = alu_data_q;
    end else if (gnt_mem) begin
      WE3_o = 1'b1;
      AD3_o = mem_addr_q;
      WD3_o = mem_data_q;
    end

    // Ready depends only on state and grant, so a buffer can drain and refill on one edge.
    alu_ready_o = ~alu_full_q | gnt_alu;
    mem_ready_o = ~mem_full_q | gnt_mem;

    hazard_o = (alu_full_q && (((rs1_i != '0) && (rs1_i == alu_addr_q)) ||
                               ((rs2_i != '0) && (rs2_i == alu_addr_q)))) ||
               (mem_full_q && (((rs1_i != '0) && (rs1_i == mem_addr_q)) ||
                               ((rs2_i != '0) && (rs2_i == mem_addr_q)))) ||
               (trig_pend_q && ((rs1_i == TrigAddr) || (rs2_i == TrigAddr)));

    busy_o = alu_full_q | mem_full_q | trig_pend_q;
  end

  assign alu_hs = alu_valid_i & alu_ready_o;
  assign mem_hs = mem_valid_i & mem_ready_o;

  // Next-state for buffers and trigger; writes to x0 are accepted but never buffered.
  always_comb begin
    alu_full_d = alu_full_q & ~gnt_alu;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    if (alu_hs) begin
      alu_full_d = (alu_addr_i != '0);
      alu_addr_d = alu_addr_i;
      alu_data_d = alu_data_i;
    end

    mem_full_d = mem_full_q & ~gnt_mem;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (mem_hs) begin
      mem_full_d = (mem_addr_i != '0);
      mem_addr_d = mem_addr_i;
      mem_data_d = mem_data_i;
    end

    // A new request at the granting edge keeps the trigger pending.
    trig_pend_d = trigger_i | (trig_pend_q & ~gnt_trig);
  end

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // After a buffer grant, prefer the other requester.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_alu) begin
      rr_ptr_d = 1'b1;
    end else if (gnt_mem) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Buffer and trigger state; reset drops any buffered write immediately.
  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alu_full_q  <= 1'b0;
      alu_addr_q  <= '0;
      alu_data_q  <= '0;
      mem_full_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      trig_pend_q <= 1'b0;
    end else begin
      alu_full_q  <= alu_full_d;
      alu_addr_q  <= alu_addr_d;
      alu_data_q  <= alu_data_d;
      mem_full_q  <= mem_full_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      trig_pend_q <= trig_pend_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_regfile_write_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int TRIG = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, alu_ready, mem_valid, mem_ready, trigger;
  logic [AW-1:0] alu_addr, mem_addr, rs1, rs2, ad3;
  logic [DW-1:0] alu_data, mem_data, wd3;
  logic          we3, hazard, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .TRIGGER_REG  (TRIG)
  ) dut (
    .clk        (clk),
    .rst_n_i    (rst_n),
    .alu_valid_i(alu_valid),
    .alu_ready_o(alu_ready),
    .alu_addr_i (alu_addr),
    .alu_data_i (alu_data),
    .mem_valid_i(mem_valid),
    .mem_ready_o(mem_ready),
    .mem_addr_i (mem_addr),
    .mem_data_i (mem_data),
    .trigger_i  (trigger),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .hazard_o   (hazard),
    .AD3_o      (ad3),
    .WE3_o      (we3),
    .WD3_o      (wd3),
    .busy_o     (busy)
  );

  task automatic drive_idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    trigger   = 1'b0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    #3;
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL reset_we3: got %b want 0", we3); end
    n_vec++; if (ad3 !== '0) begin n_err++; $display("FAIL reset_ad3: got %0d want 0", ad3); end
    n_vec++; if (wd3 !== '0) begin n_err++; $display("FAIL reset_wd3: got %h want 0", wd3); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b want 0", hazard); end
    n_vec++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hDEAD_BEEF;
    #1;
    n_vec++; if (alu_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", alu_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++; if (we3 !== 1'b1) begin n_err++; $display("FAIL single_we3: got %b want 1", we3); end
    n_vec++; if (ad3 !== 5'd3) begin n_err++; $display("FAIL single_ad3: got %0d want 3", ad3); end
    n_vec++;
    if (wd3 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wd3: got %h want deadbeef", wd3); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy1: got %b want 1", busy); end
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy2: got %b want 0", busy); end
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL single_we3_idle: got %b want 0", we3); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h9999_0000;
    mem_valid = 1'b1; mem_addr = 5'd10; mem_data = 32'hAAAA_0000;
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL midrst_we3: got %b want 0", we3); end
    n_vec++; if (ad3 !== '0) begin n_err++; $display("FAIL midrst_ad3: got %0d want 0", ad3); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
      n_err++; $display("FAIL midrst_ready: got alu=%b mem=%b want 1/1", alu_ready, mem_ready);
    end
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL midrst_we3_post: got %b want 0", we3); end
  endtask

  task automatic test_contention();
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_alu_rdy;
    int            cnt;
    do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'h2222_2222;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); #1;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      exp_addr    = (k % 2 == 1) ? 5'd1 : 5'd2;
      exp_alu_rdy = (k % 2 == 1);
`else
      exp_addr    = 5'd2;
      exp_alu_rdy = 1'b0;
`endif
      exp_data = (exp_addr == 5'd1) ? 32'h1111_1111 : 32'h2222_2222;
      n_vec++; if (we3 !== 1'b1) begin n_err++; $display("FAIL cont_we3[%0d]: got %b want 1", k, we3); end
      n_vec++;
      if (ad3 !== exp_addr) begin n_err++; $display("FAIL cont_ad3[%0d]: got %0d want %0d", k, ad3, exp_addr); end
      n_vec++;
      if (wd3 !== exp_data) begin n_err++; $display("FAIL cont_wd3[%0d]: got %h want %h", k, wd3, exp_data); end
      n_vec++;
      if (alu_ready !== exp_alu_rdy) begin
        n_err++; $display("FAIL cont_alu_rdy[%0d]: got %b want %b", k, alu_ready, exp_alu_rdy);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 8) begin
      @(negedge clk); #1;
      cnt++;
    end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL cont_drain: busy got %b want 0 after %0d", busy, cnt); end
  endtask

  task automatic test_trigger();
    logic [AW-1:0] first_addr, second_addr;
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
    first_addr = 5'd4; second_addr = 5'd6;
`else
    first_addr = 5'd6; second_addr = 5'd4;
`endif
    do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
    trigger   = 1'b1;
    @(negedge clk);
    drive_idle();
    rs1 = 5'(TRIG);
    #1;
    n_vec++;
    if (we3 !== 1'b1 || ad3 !== 5'(TRIG) || wd3 !== 32'd1) begin
      n_err++; $display("FAIL trig_write: got we=%b ad=%0d wd=%h want 1/%0d/1", we3, ad3, wd3, TRIG);
    end
    n_vec++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      n_err++; $display("FAIL trig_stall: got alu=%b mem=%b want 0/0", alu_ready, mem_ready);
    end
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL trig_hazard: got %b want 1", hazard); end
    rs1 = '0;
    @(negedge clk); #1;
    n_vec++;
    if (we3 !== 1'b1 || ad3 !== first_addr) begin
      n_err++; $display("FAIL trig_drain1: got we=%b ad=%0d want 1/%0d", we3, ad3, first_addr);
    end
    @(negedge clk); #1;
    n_vec++;
    if (we3 !== 1'b1 || ad3 !== second_addr) begin
      n_err++; $display("FAIL trig_drain2: got we=%b ad=%0d want 1/%0d", we3, ad3, second_addr);
    end
    @(negedge clk); #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL trig_busy: got %b want 0", busy); end

    // Held trigger: one write per cycle after the first edge, plus one after release.
    @(negedge clk);
    trigger = 1'b1;
    #1;
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL trig_lvl0: got we=%b want 0", we3); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 3) trigger = 1'b0;
      #1;
      n_vec++;
      if (we3 !== 1'b1 || ad3 !== 5'(TRIG)) begin
        n_err++; $display("FAIL trig_lvl[%0d]: got we=%b ad=%0d want 1/%0d", k, we3, ad3, TRIG);
      end
    end
    @(negedge clk); #1;
    n_vec++;
    if (we3 !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL trig_lvl_end: got we=%b busy=%b want 0/0", we3, busy);
    end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = '0; mem_data = 32'h1234;
    #1;
    n_vec++; if (mem_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %b want 1", mem_ready); end
    @(negedge clk);
    drive_idle();
    #1;
    n_vec++;
    if (we3 !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL x0_write: got we=%b busy=%b want 0/0", we3, busy);
    end
    @(negedge clk); #1;
    n_vec++; if (we3 !== 1'b0) begin n_err++; $display("FAIL x0_late: got we=%b want 0", we3); end
  endtask

  task automatic test_hazard();
    do_reset();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77;
    @(negedge clk);
    drive_idle();
    rs1 = 5'd7;
    #1;
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_rs1: got %b want 1", hazard); end
    rs1 = '0; rs2 = 5'd7;
    #1;
    n_vec++; if (hazard !== 1'b1) begin n_err++; $display("FAIL haz_rs2: got %b want 1", hazard); end
    rs1 = '0; rs2 = 5'd8;
    #1;
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_clear: got %b want 0", hazard); end
    @(negedge clk);
    rs1 = 5'd7; rs2 = '0;
    #1;
    n_vec++; if (hazard !== 1'b0) begin n_err++; $display("FAIL haz_after: got %b want 0", hazard); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_midop();
    test_contention();
    test_trigger();
    test_x0();
    test_hazard();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
